// File: rtl/dsp_simd_mul2_int9u8.sv
// Two-lane SIMD INT9 x UINT8 multiplier packed into one DSP48-style product.
// Optional macro SIMDMUL_COMP_EN adds a fabric stage that folds the lane-0 borrow into out_h.
module dsp_simd_mul2_int9u8 #(
    parameter int IN_REG = 1,
    parameter int MREG   = 1
) (
    input  logic        clk,
    input  logic        aresetn,
    input  logic        clken,
    input  logic        dsp_reset,
    input  logic        in_valid,
    input  logic [8:0]  coef,
    input  logic [7:0]  pix0,
    input  logic [7:0]  pix1,
    output logic [17:0] out_l,
    output logic [17:0] out_h,
    output logic        out_cin,
    output logic        out_valid
);

`ifdef SIMDMUL_COMP_EN
    localparam int LATENCY = IN_REG + MREG + 2;
`else
    localparam int LATENCY = IN_REG + MREG + 1;
`endif

    logic [25:0] a_pack;
    logic [25:0] a_s;
    logic [8:0]  b_s;
    logic signed [35:0] a_ext;
    logic signed [35:0] b_ext;
    logic signed [35:0] m_comb;
    logic signed [35:0] m_s;
    logic [35:0] p_q;
    logic [LATENCY-1:0] vld;

    // Lane 1 sits 18 bits above lane 0 so the lane-0 product never overlaps it.
    assign a_pack = {pix1, 10'b0, pix0};

    generate
        if (IN_REG != 0) begin : g_in_reg
            logic [25:0] a_q;
            logic [8:0]  b_q;
            always_ff @(posedge clk or negedge aresetn) begin
                if (!aresetn) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (clken) begin
                    if (dsp_reset) begin
                        a_q <= '0;
                        b_q <= '0;
                    end else begin
                        a_q <= a_pack;
                        b_q <= coef;
                    end
                end
            end
            assign a_s = a_q;
            assign b_s = b_q;
        end else begin : g_in_bypass
            assign a_s = a_pack;
            assign b_s = coef;
        end
    endgenerate

    assign a_ext  = {10'b0, a_s};
    assign b_ext  = {{27{b_s[8]}}, b_s};
    assign m_comb = b_ext * a_ext;

    generate
        if (MREG != 0) begin : g_m_reg
            logic signed [35:0] m_q;
            always_ff @(posedge clk or negedge aresetn) begin
                if (!aresetn) begin
                    m_q <= '0;
                end else if (clken) begin
                    if (dsp_reset) begin
                        m_q <= '0;
                    end else begin
                        m_q <= m_comb;
                    end
                end
            end
            assign m_s = m_q;
        end else begin : g_m_bypass
            assign m_s = m_comb;
        end
    endgenerate

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            p_q <= '0;
        end else if (clken) begin
            if (dsp_reset) begin
                p_q <= '0;
            end else begin
                p_q <= m_s;
            end
        end
    end

`ifdef SIMDMUL_COMP_EN
    logic [17:0] l_q;
    logic [17:0] h_q;

    // Negative lane 0 borrowed one from the upper field; give it back here.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            l_q <= '0;
            h_q <= '0;
        end else if (clken) begin
            if (dsp_reset) begin
                l_q <= '0;
                h_q <= '0;
            end else begin
                l_q <= p_q[17:0];
                h_q <= p_q[35:18] + {17'b0, p_q[17]};
            end
        end
    end

    assign out_l   = l_q;
    assign out_h   = h_q;
    assign out_cin = 1'b0;
`else
    assign out_l   = p_q[17:0];
    assign out_h   = p_q[35:18];
    assign out_cin = p_q[17];
`endif

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            vld <= '0;
        end else if (clken) begin
            if (dsp_reset) begin
                vld <= '0;
            end else begin
                vld[0] <= in_valid;
                for (int i = 1; i < LATENCY; i++) begin
                    vld[i] <= vld[i-1];
                end
            end
        end
    end

    assign out_valid = vld[LATENCY-1];

endmodule
